// File: rtl/gen_pulse_poly.sv
// gen_pulse_poly: MIDI-driven polyphonic pulse-wave generator; all voices are summed once per sample trigger.
// Optional macro GEN_PULSE_POLY_PWM_EN: CC1 on MIDI_CH sets the shared duty cycle (default build: fixed 50%).
module gen_pulse_poly #(
    parameter int NUM_VOICES    = 4,
    parameter int PHASE_W       = 24,
    parameter int SAMPLE_W      = 18,
    parameter int MIDI_CH       = 0,
    parameter int MIDI_CMD_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       midi_rdy,
    input  logic [MIDI_CMD_SIZE-1:0]   midi_cmd,
    input  logic [3:0]                 midi_ch_sysn,
    input  logic [6:0]                 midi_data0,
    input  logic [6:0]                 midi_data1,
    input  logic                       sample_rate_trig,
    output logic                       sample_out_rdy,
    output logic signed [SAMPLE_W-1:0] sample_out_l,
    output logic signed [SAMPLE_W-1:0] sample_out_r
);
    localparam int VW     = $clog2(NUM_VOICES);
    localparam int AMP_SH = SAMPLE_W - 9 - VW;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF = MIDI_CMD_SIZE'(8);
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON  = MIDI_CMD_SIZE'(9);
    localparam logic [PHASE_W-1:0]       DUTY_HALF = PHASE_W'(1) << (PHASE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACCUM, S_DONE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [VW-1:0]              r_vidx, r_steal_ptr, w_sel, w_hit_idx, w_free_idx, w_rd_idx;
    logic                       r_active [NUM_VOICES];
    logic [6:0]                 r_note   [NUM_VOICES];
    logic [6:0]                 r_vel    [NUM_VOICES];
    logic [PHASE_W-1:0]         r_phase  [NUM_VOICES];
    logic [PHASE_W-1:0]         w_rom    [128];
    logic [PHASE_W-1:0]         r_inc_p1, w_duty;
    logic signed [SAMPLE_W-1:0] r_acc, w_amp, w_contrib, w_acc_nxt, r_sample;
    logic                       r_rdy, w_msg_ok, w_note_on, w_note_off, w_hit, w_free, w_last;

    function automatic logic [PHASE_W-1:0] note_inc(input int n);
        real f;
        f = 440.0 * (2.0 ** ((n - 69) / 12.0)) * (2.0 ** PHASE_W) / 48000.0;
        return PHASE_W'($rtoi(f + 0.5));
    endfunction

    for (genvar g = 0; g < 128; g++) begin : g_rom
        assign w_rom[g] = note_inc(g);
    end

    assign w_msg_ok   = midi_rdy && (midi_ch_sysn == 4'(MIDI_CH));
    assign w_note_on  = w_msg_ok && (midi_cmd == MIDI_CMD_NOTE_ON) && (midi_data1 != 7'd0);
    assign w_note_off = w_msg_ok && ((midi_cmd == MIDI_CMD_NOTE_OFF) ||
                                     ((midi_cmd == MIDI_CMD_NOTE_ON) && (midi_data1 == 7'd0)));

    // Retrigger beats free voice beats steal; descending scan leaves the lowest index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_note[v] == midi_data0)) begin
                w_hit     = 1'b1;
                w_hit_idx = VW'(v);
            end
            if (!r_active[v]) begin
                w_free     = 1'b1;
                w_free_idx = VW'(v);
            end
        end
        w_sel = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_steal_ptr);
    end

`ifdef GEN_PULSE_POLY_PWM_EN
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC = MIDI_CMD_SIZE'(11);
    localparam logic [PHASE_W-1:0]       DUTY_MIN    = PHASE_W'(1) << (PHASE_W - 7);
    logic [PHASE_W-1:0] r_duty;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_duty <= DUTY_HALF;
        else if (w_msg_ok && (midi_cmd == MIDI_CMD_CC) && (midi_data0 == 7'd1))
            r_duty <= (midi_data1 == 7'd0) ? DUTY_MIN : {midi_data1, {(PHASE_W - 7){1'b0}}};
    end
    assign w_duty = r_duty;
`else
    assign w_duty = DUTY_HALF;
`endif

    // Voice state: the scan's phase update is issued first so a same-cycle MIDI write wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_active[v] <= 1'b0;
                r_phase[v]  <= '0;
            end
            r_steal_ptr <= '0;
        end else begin
            if ((r_state == S_ACCUM) && r_active[r_vidx])
                r_phase[r_vidx] <= r_phase[r_vidx] + r_inc_p1;
            if (w_note_on) begin
                r_active[w_sel] <= 1'b1;
                r_note[w_sel]   <= midi_data0;
                r_vel[w_sel]    <= midi_data1;
                r_phase[w_sel]  <= '0;
                if (!w_hit && !w_free)
                    r_steal_ptr <= r_steal_ptr + VW'(1);
            end
            if (w_note_off) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (r_active[v] && (r_note[v] == midi_data0))
                        r_active[v] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    assign w_last = (r_vidx == VW'(NUM_VOICES - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (sample_rate_trig) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p1: increment ROM read one voice ahead of the accumulate stage
    assign w_rd_idx = (r_state == S_FETCH) ? '0 : r_vidx + VW'(1);

    always_ff @(posedge clk) begin
        r_inc_p1 <= w_rom[r_note[w_rd_idx]];
    end

    assign w_amp     = $signed({{(SAMPLE_W - 7){1'b0}}, r_vel[r_vidx]}) <<< AMP_SH;
    assign w_contrib = !r_active[r_vidx] ? '0 : ((r_phase[r_vidx] < w_duty) ? w_amp : -w_amp);
    assign w_acc_nxt = r_acc + w_contrib;

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && sample_rate_trig) begin
            r_vidx <= '0;
            r_acc  <= '0;
        end else if (r_state == S_ACCUM) begin
            r_vidx <= r_vidx + VW'(1);
            r_acc  <= w_acc_nxt;
        end
    end

    // p2: the last voice's sum is registered straight onto the outputs, valid during DONE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdy    <= 1'b0;
            r_sample <= '0;
        end else begin
            r_rdy <= (r_state == S_ACCUM) && w_last;
            if ((r_state == S_ACCUM) && w_last)
                r_sample <= w_acc_nxt;
        end
    end

    assign sample_out_rdy = r_rdy;
    assign sample_out_l   = r_sample;
    assign sample_out_r   = r_sample;
endmodule

// File: tb/tb_gen_pulse_poly.sv
// tb_gen_pulse_poly: random MIDI/trigger stimulus checked against a note-level voice model every cycle.
// Build with +define+GEN_PULSE_POLY_PWM_EN to also cover the CC1 duty controller.
`timescale 1ns/1ps
module tb_gen_pulse_poly;
    localparam int     NV      = 4;
    localparam int     PW      = 24;
    localparam int     SW      = 18;
    localparam int     CH      = 0;
    localparam int     AMP_MUL = 1 << (SW - 9 - $clog2(NV));
    localparam longint PMOD    = 64'd1 << PW;
    localparam int     C_OFF = 8, C_ON = 9, C_CC = 11;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 midi_rdy;
    logic [3:0]           midi_cmd;
    logic [3:0]           midi_ch_sysn;
    logic [6:0]           midi_data0, midi_data1;
    logic                 sample_rate_trig;
    logic                 sample_out_rdy;
    logic signed [SW-1:0] sample_out_l, sample_out_r;

    gen_pulse_poly #(
        .NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .MIDI_CH(CH), .MIDI_CMD_SIZE(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .midi_rdy(midi_rdy), .midi_cmd(midi_cmd),
        .midi_ch_sysn(midi_ch_sysn), .midi_data0(midi_data0), .midi_data1(midi_data1),
        .sample_rate_trig(sample_rate_trig), .sample_out_rdy(sample_out_rdy),
        .sample_out_l(sample_out_l), .sample_out_r(sample_out_r)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit exp_rdy;
    int q_due[$];
    int q_val[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Note-level model of the voice bank
    bit     m_act   [NV];
    int     m_note  [NV];
    int     m_vel   [NV];
    longint m_phase [NV];
    longint m_inc   [128];
    int     m_steal;
    longint m_duty;

    task automatic check(input string name, input longint got, input longint want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v]   = 1'b0;
            m_phase[v] = 0;
        end
        m_steal = 0;
        m_duty  = PMOD / 2;
    endtask

    task automatic model_midi(input int cmd, input int ch, input int d0, input int d1);
        int sel;
        if (ch != CH) return;
        if (cmd == C_ON && d1 != 0) begin
            sel = -1;
            for (int v = 0; v < NV; v++)
                if (sel < 0 && m_act[v] && m_note[v] == d0) sel = v;
            for (int v = 0; v < NV; v++)
                if (sel < 0 && !m_act[v]) sel = v;
            if (sel < 0) begin
                sel     = m_steal;
                m_steal = (m_steal + 1) % NV;
            end
            m_act[sel]   = 1'b1;
            m_note[sel]  = d0;
            m_vel[sel]   = d1;
            m_phase[sel] = 0;
        end else if (cmd == C_OFF || cmd == C_ON) begin
            for (int v = 0; v < NV; v++)
                if (m_act[v] && m_note[v] == d0) m_act[v] = 1'b0;
        end else if (cmd == C_CC && d0 == 1) begin
`ifdef GEN_PULSE_POLY_PWM_EN
            m_duty = (d1 == 0) ? (PMOD >> 7) : longint'(d1) * (PMOD >> 7);
`endif
        end
    endtask

    task automatic model_trig(output int e);
        e = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_act[v]) begin
                e += (m_phase[v] < m_duty) ? m_vel[v] * AMP_MUL : -m_vel[v] * AMP_MUL;
                m_phase[v] = (m_phase[v] + m_inc[m_note[v]]) % PMOD;
            end
        end
    endtask

    // Every cycle: the strobe must appear exactly when a queued sample falls due
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rdy = (q_due.size() > 0) && (q_due[0] == cyc);
            check("rdy_timing", longint'(sample_out_rdy), longint'(exp_rdy));
            if (exp_rdy) begin
                check("sample_l", sample_out_l, q_val[0]);
                check("sample_r", sample_out_r, q_val[0]);
            end
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                void'(q_due.pop_front());
                void'(q_val.pop_front());
            end
        end
    end

    task automatic send_midi(input int cmd, input int ch, input int d0, input int d1);
        midi_cmd     = 4'(cmd);
        midi_ch_sysn = 4'(ch);
        midi_data0   = 7'(d0);
        midi_data1   = 7'(d1);
        midi_rdy     = 1'b1;
        @(negedge clk);
        midi_rdy     = 1'b0;
        midi_cmd     = 4'($urandom);
        midi_ch_sysn = 4'($urandom);
        midi_data0   = 7'($urandom);
        midi_data1   = 7'($urandom);
        model_midi(cmd, ch, d0, d1);
    endtask

    task automatic do_trig(output longint s);
        int e;
        bit got;
        model_trig(e);
        q_due.push_back(cyc + NV + 2);
        q_val.push_back(e);
        sample_rate_trig = 1'b1;
        @(negedge clk);
        sample_rate_trig = 1'b0;
        got = 1'b0;
        s   = 0;
        for (int i = 0; i < NV + 4; i++) begin
            if (sample_out_rdy) begin
                s   = sample_out_l;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rdy_seen", longint'(got), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        longint s;
        int     r, nmsg;
        for (int n = 0; n < 128; n++)
            m_inc[n] = longint'($rtoi(440.0 * (2.0 ** ((n - 69) / 12.0)) * (2.0 ** PW) / 48000.0 + 0.5));
        model_reset();
        midi_rdy = 1'b0; midi_cmd = '0; midi_ch_sysn = '0; midi_data0 = '0; midi_data1 = '0;
        sample_rate_trig = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        check("reset_rdy", longint'(sample_out_rdy), 0);
        check("reset_l", sample_out_l, 0);
        check("reset_r", sample_out_r, 0);

        for (int j = 0; j < 10; j++) begin
            do_trig(s);
            check("silent_sample", s, 0);
        end

        send_midi(C_ON, CH, 69, 48);
        for (int j = 0; j < 60; j++) begin
            do_trig(s);
            if (j == 0)  check("a4_first", s, 6144);
            if (j == 54) check("a4_last_high", s, 6144);
            if (j == 55) check("a4_first_low", s, -6144);
        end
        send_midi(C_ON, CH, 69, 0);
        do_trig(s);
        check("vel0_release", s, 0);
        send_midi(C_ON, 3, 69, 48);
        do_trig(s);
        check("wrong_channel", s, 0);

        do_reset(2);
        send_midi(C_ON, CH, 60, 10);
        send_midi(C_ON, CH, 64, 10);
        send_midi(C_ON, CH, 67, 10);
        send_midi(C_ON, CH, 72, 10);
        send_midi(C_ON, CH, 76, 10);
        do_trig(s);
        check("full_bank", s, 5120);
        send_midi(C_OFF, CH, 60, 0);
        do_trig(s);
        check("off_stolen_note", s, 5120);
        send_midi(C_ON, CH, 79, 20);
        send_midi(C_OFF, CH, 64, 0);
        do_trig(s);
        check("second_steal", s, 6400);
        send_midi(C_OFF, CH, 79, 0);
        do_trig(s);
        check("release_79", s, 3840);

        do_reset(2);
        send_midi(C_CC, CH, 1, 32);
        send_midi(C_ON, CH, 69, 48);
        for (int j = 0; j < 30; j++) begin
            do_trig(s);
            if (j == 27) check("duty25_high", s, 6144);
`ifdef GEN_PULSE_POLY_PWM_EN
            if (j == 28) check("duty25_low", s, -6144);
`else
            if (j == 28) check("cc_ignored", s, 6144);
`endif
        end
        do_reset(2);
        send_midi(C_CC, CH, 1, 0);
        send_midi(C_ON, CH, 69, 48);
        do_trig(s);
        check("duty_clamp_first", s, 6144);
        do_trig(s);
`ifdef GEN_PULSE_POLY_PWM_EN
        check("duty_clamp_second", s, -6144);
`else
        check("duty_fixed_second", s, 6144);
`endif

        sample_rate_trig = 1'b1;
        @(negedge clk);
        sample_rate_trig = 1'b0;
        @(negedge clk);
        do_reset(2);
        repeat (NV + 4) @(negedge clk);
        check("abort_out", sample_out_l, 0);
        do_trig(s);
        check("abort_voices_cleared", s, 0);

        for (int it = 0; it < 300; it++) begin
            nmsg = $urandom_range(0, 3);
            for (int k = 0; k < nmsg; k++) begin
                r = $urandom_range(0, 9);
                if (r <= 4)      send_midi(C_ON, CH, 60 + $urandom_range(0, 7),
                                           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127));
                else if (r <= 6) send_midi(C_OFF, CH, 60 + $urandom_range(0, 7), $urandom_range(0, 127));
                else if (r == 7) send_midi(C_CC, CH, $urandom_range(1, 2), $urandom_range(0, 127));
                else if (r == 8) send_midi(10, CH, 60 + $urandom_range(0, 7), $urandom_range(1, 127));
                else             send_midi(C_ON, $urandom_range(1, 15), 60 + $urandom_range(0, 7), 64);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_trig(s);
        end

        repeat (NV + 4) @(negedge clk);
        check("queue_drained", q_due.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
